// File: rtl/commit_rat.sv
// rtl/commit_rat.sv - ROB-head commit stage with architectural regfile and register alias table
//
// Retires the ROB head entry when it is valid and done. On retirement it writes the
// architectural register file and releases the RAT mapping, unless a younger producer
// owns that register. Dispatch renames destinations into the RAT. Dispatch also
// performs operand lookup through two read ports, which see the same-cycle commit
// through a bypass.
//
// Optional feature macro: COMMIT_RAT_PERF_EN adds the instret_o and stall_cycles_o
// performance counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rob_head_*                ROB head entry (valid, done, rd, data, index)
//   commit_stall              hold commit this cycle
//   dequeue_o                 commit fires this cycle (combinational)
//   ren_valid/rd_addr/rob_idx dispatch rename request
//   rs1/rs2_addr              dispatch source lookups
//   rs1/rs2_data/busy/tag     lookup results
//   flush                     clear every RAT busy bit
//   instret_o, stall_cycles_o perf counters (COMMIT_RAT_PERF_EN only)
module commit_rat #(
    parameter int NUM_REGS  = 32,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rob_head_valid,
    input  logic                    rob_head_done,
    input  logic [4:0]              rob_head_rd_addr,
    input  logic [DATA_W-1:0]       rob_head_rd_data,
    input  logic [ROB_IDX_W-1:0]    rob_head_idx,
    input  logic                    commit_stall,
    output logic                    dequeue_o,
    input  logic                    ren_valid,
    input  logic [4:0]              ren_rd_addr,
    input  logic [ROB_IDX_W-1:0]    ren_rob_idx,
    input  logic [4:0]              rs1_addr,
    input  logic [4:0]              rs2_addr,
    output logic [DATA_W-1:0]       rs1_data,
    output logic [DATA_W-1:0]       rs2_data,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [ROB_IDX_W-1:0]    rs1_tag,
    output logic [ROB_IDX_W-1:0]    rs2_tag,
`ifdef COMMIT_RAT_PERF_EN
    output logic [63:0]             instret_o,
    output logic [31:0]             stall_cycles_o,
`endif
    input  logic                    flush
);

    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;
    logic [ROB_IDX_W-1:0] r_tag  [NUM_REGS];

    logic w_commit_fire;
    logic w_ren_fire;
    logic w_ren_hits_commit;

    assign w_commit_fire     = rob_head_valid & rob_head_done & ~commit_stall & ~rst & ~flush;
    assign dequeue_o         = w_commit_fire;
    assign w_ren_fire        = ren_valid & (ren_rd_addr != 5'd0);
    assign w_ren_hits_commit = w_ren_fire & (ren_rd_addr == rob_head_rd_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_busy <= '0;
        end else if (flush) begin
            // Mispredict recovery: mappings drop, committed state stays, rename discarded.
            r_busy <= '0;
        end else begin
            if (w_commit_fire && rob_head_rd_addr != 5'd0) begin
                r_regs[rob_head_rd_addr] <= rob_head_rd_data;
                // Release only if the retiring entry is still the newest producer.
                if (r_tag[rob_head_rd_addr] == rob_head_idx && !w_ren_hits_commit)
                    r_busy[rob_head_rd_addr] <= 1'b0;
            end
            // Placed after the commit update so a colliding rename wins.
            if (w_ren_fire) begin
                r_busy[ren_rd_addr] <= 1'b1;
                r_tag[ren_rd_addr]  <= ren_rob_idx;
            end
        end
    end

    // Operand lookup. The same-cycle commit is forwarded so dispatch does not wait on a
    // tag that is retiring right now.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        rs1_tag  = '0;
        if (rs1_addr != 5'd0) begin
            if (r_busy[rs1_addr] && w_commit_fire && r_tag[rs1_addr] == rob_head_idx
                && rob_head_rd_addr == rs1_addr) begin
                rs1_data = rob_head_rd_data;
                rs1_tag  = r_tag[rs1_addr];
            end else begin
                rs1_data = r_regs[rs1_addr];
                rs1_busy = r_busy[rs1_addr];
                rs1_tag  = r_tag[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        rs2_tag  = '0;
        if (rs2_addr != 5'd0) begin
            if (r_busy[rs2_addr] && w_commit_fire && r_tag[rs2_addr] == rob_head_idx
                && rob_head_rd_addr == rs2_addr) begin
                rs2_data = rob_head_rd_data;
                rs2_tag  = r_tag[rs2_addr];
            end else begin
                rs2_data = r_regs[rs2_addr];
                rs2_busy = r_busy[rs2_addr];
                rs2_tag  = r_tag[rs2_addr];
            end
        end
    end

`ifdef COMMIT_RAT_PERF_EN
    logic [63:0] r_instret;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret      <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_commit_fire && r_instret != '1)
                r_instret <= r_instret + 64'd1;
            if (rob_head_valid && !w_commit_fire && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign instret_o      = r_instret;
    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule

// File: tb/tb_commit_rat.sv
// tb/tb_commit_rat.sv - directed self-checking bench for commit_rat
module tb_commit_rat;

    logic        clk;
    logic        rst;
    logic        rob_head_valid;
    logic        rob_head_done;
    logic [4:0]  rob_head_rd_addr;
    logic [31:0] rob_head_rd_data;
    logic [4:0]  rob_head_idx;
    logic        commit_stall;
    logic        dequeue_o;
    logic        ren_valid;
    logic [4:0]  ren_rd_addr;
    logic [4:0]  ren_rob_idx;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_tag;
    logic        flush;
`ifdef COMMIT_RAT_PERF_EN
    logic [63:0] instret_o;
    logic [31:0] stall_cycles_o;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    commit_rat dut (
        .clk              (clk),
        .rst              (rst),
        .rob_head_valid   (rob_head_valid),
        .rob_head_done    (rob_head_done),
        .rob_head_rd_addr (rob_head_rd_addr),
        .rob_head_rd_data (rob_head_rd_data),
        .rob_head_idx     (rob_head_idx),
        .commit_stall     (commit_stall),
        .dequeue_o        (dequeue_o),
        .ren_valid        (ren_valid),
        .ren_rd_addr      (ren_rd_addr),
        .ren_rob_idx      (ren_rob_idx),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rs1_busy         (rs1_busy),
        .rs2_busy         (rs2_busy),
        .rs1_tag          (rs1_tag),
        .rs2_tag          (rs2_tag),
`ifdef COMMIT_RAT_PERF_EN
        .instret_o        (instret_o),
        .stall_cycles_o   (stall_cycles_o),
`endif
        .flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic v, input logic d, input logic [4:0] rd,
                        input logic [31:0] data, input logic [4:0] idx);
        rob_head_valid   = v;
        rob_head_done    = d;
        rob_head_rd_addr = rd;
        rob_head_rd_data = data;
        rob_head_idx     = idx;
    endtask

    task automatic ren(input logic v, input logic [4:0] rd, input logic [4:0] tg);
        ren_valid   = v;
        ren_rd_addr = rd;
        ren_rob_idx = tg;
    endtask

    initial begin
        rst = 1'b1;
        commit_stall = 1'b0;
        flush = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        ren(1'b0, 5'd0, 5'd0);
        head(1'b1, 1'b1, 5'd5, 32'h1, 5'd0);
        #1;
        check("deq_in_reset", dequeue_o, 0);
        tick();
        tick();
        rst = 1'b0;
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        rs1_addr = 5'd5;
        #1;
        check("reset_x5_data", rs1_data, 0);
        check("reset_x5_busy", rs1_busy, 0);
        check("reset_x5_tag", rs1_tag, 0);

        // Rename then commit
        ren(1'b1, 5'd5, 5'd3);
        tick();
        ren(1'b0, 5'd0, 5'd0);
        #1;
        check("ren_x5_busy", rs1_busy, 1);
        check("ren_x5_tag", rs1_tag, 3);
        head(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd3);
        #1;
        check("commit_deq", dequeue_o, 1);
        tick();
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        #1;
        check("commit_x5_busy", rs1_busy, 0);
        check("commit_x5_data", rs1_data, 32'hDEADBEEF);

        // Younger producer retained
        ren(1'b1, 5'd7, 5'd2);
        tick();
        ren(1'b1, 5'd7, 5'd4);
        tick();
        ren(1'b0, 5'd0, 5'd0);
        head(1'b1, 1'b1, 5'd7, 32'h11, 5'd2);
        tick();
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        rs1_addr = 5'd7;
        #1;
        check("young_x7_data", rs1_data, 32'h11);
        check("young_x7_busy", rs1_busy, 1);
        check("young_x7_tag", rs1_tag, 4);

        // Same-cycle bypass
        ren(1'b1, 5'd9, 5'd6);
        tick();
        ren(1'b0, 5'd0, 5'd0);
        head(1'b1, 1'b1, 5'd9, 32'h55, 5'd6);
        rs2_addr = 5'd9;
        #1;
        check("byp_rs2_busy", rs2_busy, 0);
        check("byp_rs2_data", rs2_data, 32'h55);
        tick();
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        #1;
        check("byp_after_busy", rs2_busy, 0);
        check("byp_after_data", rs2_data, 32'h55);

        // Commit/rename collision on x4
        ren(1'b1, 5'd4, 5'd1);
        tick();
        head(1'b1, 1'b1, 5'd4, 32'hA5A5A5A5, 5'd1);
        ren(1'b1, 5'd4, 5'd8);
        tick();
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        ren(1'b0, 5'd0, 5'd0);
        rs1_addr = 5'd4;
        #1;
        check("coll_x4_data", rs1_data, 32'hA5A5A5A5);
        check("coll_x4_busy", rs1_busy, 1);
        check("coll_x4_tag", rs1_tag, 8);

        // Not done and stall leave state untouched
        rs1_addr = 5'd5;
        head(1'b1, 1'b0, 5'd5, 32'h1234, 5'd0);
        #1;
        check("notdone_deq", dequeue_o, 0);
        tick();
        head(1'b1, 1'b1, 5'd5, 32'h1234, 5'd0);
        commit_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_deq", dequeue_o, 0);
            tick();
        end
        commit_stall = 1'b0;
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        #1;
        check("stall_x5_data", rs1_data, 32'hDEADBEEF);

        // x0 never written, never busy
        head(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd2);
        ren(1'b1, 5'd0, 5'd7);
        #1;
        check("x0_commit_deq", dequeue_o, 1);
        tick();
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        ren(1'b0, 5'd0, 5'd0);
        rs1_addr = 5'd0;
        #1;
        check("x0_data", rs1_data, 0);
        check("x0_busy", rs1_busy, 0);

        // Flush
        ren(1'b1, 5'd3, 5'd10);
        tick();
        ren(1'b1, 5'd8, 5'd11);
        tick();
        ren(1'b0, 5'd0, 5'd0);
        rs1_addr = 5'd3;
        rs2_addr = 5'd8;
        #1;
        check("pre_flush_x3_busy", rs1_busy, 1);
        check("pre_flush_x8_busy", rs2_busy, 1);
        flush = 1'b1;
        head(1'b1, 1'b1, 5'd3, 32'h77, 5'd10);
        ren(1'b1, 5'd12, 5'd13);
        #1;
        check("flush_deq", dequeue_o, 0);
        tick();
        flush = 1'b0;
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        ren(1'b0, 5'd0, 5'd0);
        #1;
        check("flush_x3_busy", rs1_busy, 0);
        check("flush_x3_data", rs1_data, 0);
        check("flush_x8_busy", rs2_busy, 0);
        rs2_addr = 5'd12;
        #1;
        check("flush_x12_busy", rs2_busy, 0);
        rs2_addr = 5'd7;
        #1;
        check("flush_x7_data", rs2_data, 32'h11);

        // Reset mid-stream
        ren(1'b1, 5'd6, 5'd5);
        tick();
        ren(1'b0, 5'd0, 5'd0);
        head(1'b1, 1'b1, 5'd6, 32'h99, 5'd5);
        rst = 1'b1;
        #1;
        check("rst_mid_deq", dequeue_o, 0);
        tick();
        rst = 1'b0;
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        for (int r = 1; r < 32; r++) begin
            rs1_addr = 5'(r);
            #1;
            if (rs1_data !== 32'h0 || rs1_busy !== 1'b0)
                check($sformatf("rst_x%0d", r), {31'h0, rs1_busy, rs1_data}, 64'h0);
        end
        rs1_addr = 5'd4;
        #1;
        check("rst_x4_data", rs1_data, 0);
        check("rst_x4_busy", rs1_busy, 0);
        rs1_addr = 5'd6;
        #1;
        check("rst_x6_busy", rs1_busy, 0);

`ifdef COMMIT_RAT_PERF_EN
        check("perf_instret_rst", instret_o, 0);
        check("perf_stall_rst", stall_cycles_o, 0);
        head(1'b1, 1'b0, 5'd1, 32'h0, 5'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            head(1'b1, 1'b1, 5'd1, 32'(k), 5'(k));
            tick();
        end
        head(1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
        #1;
        check("perf_instret", instret_o, 3);
        check("perf_stall", stall_cycles_o, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
